// File: rtl/div_unit.sv
// Iterative restoring divider for RV64 M-extension DIV/DIVU/REM/REMU and their W variants.
// Retires one quotient bit per cycle; divide-by-zero and signed overflow finish in one cycle.
module div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] v, input logic w);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    state_t          state, state_nxt;
    logic [XLEN-1:0] dvsr, rem, quo;
    logic [CW-1:0]   cnt;
    logic            neg_q, neg_r, is_rem, is_word;
    logic [4:0]      rd_tag;

    logic            is_signed, a_neg, b_neg, div_zero, overflow, bypass, accept;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, bypass_val;
    logic            q_msb, ge;
    logic [XLEN:0]   rem_shift, diff;
    logic [XLEN-1:0] rem_nxt, quo_nxt, q_fin, r_fin, final_val;

    // Operand conditioning happens on the request itself so the captured state is already magnitudes.
    assign is_signed = ~op[0];
    assign a_ext = word ? (is_signed ? {{(XLEN-32){rs1_data[31]}}, rs1_data[31:0]}
                                     : {{(XLEN-32){1'b0}}, rs1_data[31:0]})
                        : rs1_data;
    assign b_ext = word ? (is_signed ? {{(XLEN-32){rs2_data[31]}}, rs2_data[31:0]}
                                     : {{(XLEN-32){1'b0}}, rs2_data[31:0]})
                        : rs2_data;
    assign a_neg = is_signed & a_ext[XLEN-1];
    assign b_neg = is_signed & b_ext[XLEN-1];
    assign a_mag = a_neg ? -a_ext : a_ext;
    assign b_mag = b_neg ? -b_ext : b_ext;

    assign div_zero = (b_ext == '0);
    assign overflow = is_signed && (&b_ext) &&
                      (word ? (rs1_data[31:0] == 32'h8000_0000)
                            : (rs1_data == {1'b1, {(XLEN-1){1'b0}}}));
    assign bypass   = div_zero | overflow;
    assign bypass_val = div_zero ? (op[1] ? a_ext : '1)
                                 : (op[1] ? '0    : a_ext);

    assign accept = start && (state != CALC) && !flush;

    // One restoring step; in word mode the dividend bits are fed from bit 31.
    assign q_msb     = is_word ? quo[31] : quo[XLEN-1];
    assign rem_shift = {rem, q_msb};
    assign ge        = (rem_shift >= {1'b0, dvsr});
    assign diff      = rem_shift - {1'b0, dvsr};
    assign rem_nxt   = ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    assign quo_nxt   = {quo[XLEN-2:0], ge};
    assign q_fin     = neg_q ? -quo_nxt : quo_nxt;
    assign r_fin     = neg_r ? -rem_nxt : rem_nxt;
    assign final_val = word_fix(is_rem ? r_fin : q_fin, is_word);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: state_nxt = accept ? (bypass ? DONE : CALC) : IDLE;
            CALC:       state_nxt = (cnt == '0) ? DONE : CALC;
            default:    state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Result and tag change only when an operation completes, so they hold through idle time.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvsr    <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            is_rem  <= 1'b0;
            is_word <= 1'b0;
            rd_tag  <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else if (accept) begin
            dvsr    <= b_mag;
            quo     <= a_mag;
            rem     <= '0;
            cnt     <= word ? CW'(31) : CW'(XLEN-1);
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            is_rem  <= op[1];
            is_word <= word;
            rd_tag  <= rd_in;
            if (bypass) begin
                result <= word_fix(bypass_val, word);
                rd_out <= rd_in;
            end
        end else if (state == CALC && !flush) begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                result <= final_val;
                rd_out <= rd_tag;
            end
        end
    end

    assign busy  = (state == CALC);
    assign valid = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: arithmetic results, latencies, corner cases, flush and reset.
module tb_div_unit;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst, flush, start, word;
    logic [1:0]  op;
    logic [63:0] rs1_data, rs2_data, result;
    logic [4:0]  rd_in, rd_out;
    logic        busy, valid;

    int errors = 0;
    int checks = 0;

    logic [63:0] res;
    int          cyc;
    logic        saw_busy;
    logic        saw_valid;

    div_unit #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op), .word(word),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
        .busy(busy), .valid(valid), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents a request for one edge; returns just after the accepting edge (cycle 1).
    task automatic startOp(input logic [1:0] o, input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] r);
        @(negedge clk);
        op = o; word = w; rs1_data = a; rs2_data = b; rd_in = r; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitValid(input int c0, output logic [63:0] rv, output int c, output logic sb);
        c  = c0;
        sb = busy;
        while (!valid && c < 200) begin
            @(posedge clk);
            #1 c++;
            sb |= busy;
        end
        rv = result;
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic w, input logic [63:0] a,
                                 input logic [63:0] b, input logic [4:0] r,
                                 output logic [63:0] rv, output int c, output logic sb);
        startOp(o, w, a, b, r);
        waitValid(1, rv, c, sb);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; start = 1'b0; word = 1'b0; op = OP_DIV;
        rs1_data = '0; rs2_data = '0; rd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_valid", 64'(valid), 64'd0);
        checkOutput("rst_result", result, 64'd0);
        checkOutput("rst_rd", 64'(rd_out), 64'd0);
        @(negedge clk) rst = 1'b0;

        applyStimulus(OP_DIVU, 1'b0, 64'd100, 64'd7, 5'd5, res, cyc, saw_busy);
        checkOutput("divu_res", res, 64'd14);
        checkOutput("divu_cyc", 64'(cyc), 64'd65);
        checkOutput("divu_rd", 64'(rd_out), 64'd5);
        @(posedge clk);
        #1;
        checkOutput("divu_valid_pulse", 64'(valid), 64'd0);
        checkOutput("divu_hold", result, 64'd14);
        checkOutput("divu_rd_hold", 64'(rd_out), 64'd5);

        applyStimulus(OP_REMU, 1'b0, 64'd100, 64'd7, 5'd6, res, cyc, saw_busy);
        checkOutput("remu_res", res, 64'd2);
        checkOutput("remu_rd", 64'(rd_out), 64'd6);

        applyStimulus(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd1, res, cyc, saw_busy);
        checkOutput("div_neg_res", res, 64'hFFFF_FFFF_FFFF_FFFD);
        checkOutput("div_neg_cyc", 64'(cyc), 64'd65);
        applyStimulus(OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd1, res, cyc, saw_busy);
        checkOutput("rem_neg_res", res, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("rem_neg_cyc", 64'(cyc), 64'd65);

        applyStimulus(OP_DIV, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd2, res, cyc, saw_busy);
        checkOutput("div_negdvsr", res, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(OP_REM, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd2, res, cyc, saw_busy);
        checkOutput("rem_negdvsr", res, 64'd1);

        applyStimulus(OP_DIVU, 1'b0, 64'd42, 64'd0, 5'd3, res, cyc, saw_busy);
        checkOutput("divz_res", res, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("divz_cyc", 64'(cyc), 64'd1);
        checkOutput("divz_busy", 64'(saw_busy), 64'd0);
        applyStimulus(OP_REM, 1'b0, 64'd5, 64'd0, 5'd4, res, cyc, saw_busy);
        checkOutput("remz_res", res, 64'd5);
        checkOutput("remz_cyc", 64'(cyc), 64'd1);
        checkOutput("remz_busy", 64'(saw_busy), 64'd0);
        checkOutput("remz_rd", 64'(rd_out), 64'd4);

        applyStimulus(OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8,
                      res, cyc, saw_busy);
        checkOutput("ovf_res", res, 64'h8000_0000_0000_0000);
        checkOutput("ovf_cyc", 64'(cyc), 64'd1);
        applyStimulus(OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9,
                      res, cyc, saw_busy);
        checkOutput("ovfw_res", res, 64'hFFFF_FFFF_8000_0000);
        checkOutput("ovfw_cyc", 64'(cyc), 64'd1);

        applyStimulus(OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd10, res, cyc, saw_busy);
        checkOutput("divuw_res", res, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("divuw_cyc", 64'(cyc), 64'd33);

        applyStimulus(OP_DIV, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 5'd11,
                      res, cyc, saw_busy);
        checkOutput("divw_garbage", res, 64'hFFFF_FFFF_FFFF_FFFD);
        checkOutput("divw_cyc", 64'(cyc), 64'd33);
        applyStimulus(OP_REMU, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'h0000_0001_0000_0007, 5'd12,
                      res, cyc, saw_busy);
        checkOutput("remuw_res", res, 64'd2);

        // A second start during CALC must be ignored, and input changes must not leak in.
        startOp(OP_DIVU, 1'b0, 64'd100, 64'd7, 5'd5);
        cyc = 1;
        while (cyc < 10) begin
            @(posedge clk);
            #1 cyc++;
        end
        @(negedge clk);
        op = OP_REMU; rs1_data = 64'd50; rs2_data = 64'd5; rd_in = 5'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitValid(11, res, cyc, saw_busy);
        checkOutput("ignore_res", res, 64'd14);
        checkOutput("ignore_cyc", 64'(cyc), 64'd65);
        checkOutput("ignore_rd", 64'(rd_out), 64'd5);

        // Flush at cycle 20 of CALC.
        startOp(OP_DIVU, 1'b0, 64'd999, 64'd3, 5'd13);
        cyc = 1;
        while (cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        checkOutput("pre_flush_busy", 64'(busy), 64'd1);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        saw_valid = valid;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1 saw_valid |= valid;
        end
        checkOutput("flush_novalid", 64'(saw_valid), 64'd0);

        // Flush beats a simultaneous start.
        @(negedge clk);
        op = OP_DIVU; word = 1'b0; rs1_data = 64'd9; rs2_data = 64'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        checkOutput("flush_start_busy", 64'(busy), 64'd0);
        checkOutput("flush_start_valid", 64'(valid), 64'd0);

        // Reset mid-CALC.
        startOp(OP_DIVU, 1'b0, 64'd1000, 64'd3, 5'd7);
        repeat (14) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_valid", 64'(valid), 64'd0);
        checkOutput("midrst_result", result, 64'd0);
        checkOutput("midrst_rd", 64'(rd_out), 64'd0);
        @(negedge clk) rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1 saw_valid |= valid;
        end
        checkOutput("midrst_novalid", 64'(saw_valid), 64'd0);

        // Back-to-back: op B requested during op A's DONE cycle.
        applyStimulus(OP_DIVU, 1'b0, 64'd1000, 64'd3, 5'd14, res, cyc, saw_busy);
        checkOutput("b2b_a_res", res, 64'd333);
        applyStimulus(OP_REMU, 1'b0, 64'd1000, 64'd3, 5'd15, res, cyc, saw_busy);
        checkOutput("b2b_b_res", res, 64'd1);
        checkOutput("b2b_b_cyc", 64'(cyc), 64'd65);
        checkOutput("b2b_b_rd", 64'(rd_out), 64'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
